// File: rtl/hazard_stall_ctrl.sv
// Hazard detection and stall sequencing for the ID stage of the 5-stage RV32 pipeline.
// Also drives the branch-compare forwarding selects and keeps a saturating stall-cycle counter.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | normal issue; hazards are checked and may start a stall
// ST_STALL | stall sequence in progress; r_cnt stall cycles remain
module hazard_stall_ctrl #(
   parameter int REG_AW    = 5,
   parameter int LU_STALLS = 1,
   parameter int AB_STALLS = 1,
   parameter int LB_STALLS = 2,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] if_id_rs1,
   input  logic [REG_AW-1:0] if_id_rs2,
   input  logic              if_id_use_rs1,
   input  logic              if_id_use_rs2,
   input  logic              branch,
   input  logic              branch_taken,
   input  logic [REG_AW-1:0] id_ex_rd,
   input  logic              id_ex_mem_read,
   input  logic              id_ex_reg_write,
   input  logic [REG_AW-1:0] ex_mem_rd,
   input  logic              ex_mem_mem_read,
   input  logic              ex_mem_reg_write,
   input  logic [REG_AW-1:0] mem_wb_rd,
   input  logic              mem_wb_reg_write,
   input  logic              kill,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              id_ex_bubble,
   output logic              if_id_flush,
   output logic [1:0]        rs1_fwd_sel,
   output logic [1:0]        rs2_fwd_sel,
   output logic [CNT_W-1:0]  stall_cycles
);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } state_t;

   localparam logic [1:0]       LU_N    = 2'(LU_STALLS);
   localparam logic [1:0]       AB_N    = 2'(AB_STALLS);
   localparam logic [1:0]       LB_N    = 2'(LB_STALLS);
   localparam logic [1:0]       LM_N    = 2'(LB_STALLS - 1);
   localparam logic [REG_AW-1:0] REG_X0 = '0;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [1:0]        r_cnt;
   logic [1:0]        w_cnt_nxt;
   logic [CNT_W-1:0]  r_stall_cycles;

   logic              w_id_ex_hit;
   logic              w_ex_mem_hit;
   logic [1:0]        w_haz_n;
   logic              w_stall;
   logic [1:0]        w_rs1_fwd;
   logic [1:0]        w_rs2_fwd;

   function automatic logic f_match(input logic [REG_AW-1:0] rd,
                                    input logic [REG_AW-1:0] rs,
                                    input logic              use_src);
      return use_src && (rd != REG_X0) && (rd == rs);
   endfunction

   function automatic logic [1:0] f_fwd(input logic [REG_AW-1:0] rs,
                                        input logic              use_src);
      logic [1:0] sel;
      sel = 2'b00;
      if (branch) begin
         if (ex_mem_reg_write && !ex_mem_mem_read && f_match(ex_mem_rd, rs, use_src))
            sel = 2'b01;
         else if (mem_wb_reg_write && f_match(mem_wb_rd, rs, use_src))
            sel = 2'b10;
      end
      return sel;
   endfunction

   assign w_id_ex_hit  = f_match(id_ex_rd, if_id_rs1, if_id_use_rs1)
                       | f_match(id_ex_rd, if_id_rs2, if_id_use_rs2);
   assign w_ex_mem_hit = f_match(ex_mem_rd, if_id_rs1, if_id_use_rs1)
                       | f_match(ex_mem_rd, if_id_rs2, if_id_use_rs2);

   assign w_rs1_fwd = f_fwd(if_id_rs1, if_id_use_rs1);
   assign w_rs2_fwd = f_fwd(if_id_rs2, if_id_use_rs2);

   // Stall length of the highest-priority hazard; 0 means no stall.
   always_comb begin
      w_haz_n = 2'd0;
      if (branch && id_ex_mem_read && id_ex_reg_write && w_id_ex_hit)
         w_haz_n = LB_N;
      else if (branch && !id_ex_mem_read && id_ex_reg_write && w_id_ex_hit)
         w_haz_n = AB_N;
      else if (branch && ex_mem_mem_read && ex_mem_reg_write && w_ex_mem_hit)
         w_haz_n = LM_N;
      else if (!branch && id_ex_mem_read && id_ex_reg_write && w_id_ex_hit)
         w_haz_n = LU_N;
   end

   assign w_stall = !reset && !kill &&
                    ((r_state == ST_STALL) || (w_haz_n != 2'd0));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= ST_RUN;
         r_cnt          <= 2'd0;
         r_stall_cycles <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_stall && (r_stall_cycles != CNT_MAX))
            r_stall_cycles <= r_stall_cycles + CNT_ONE;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (kill) begin
         w_state_nxt = ST_RUN;
         w_cnt_nxt   = 2'd0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_haz_n > 2'd1) begin
                  w_state_nxt = ST_STALL;
                  w_cnt_nxt   = w_haz_n - 2'd1;
               end else begin
                  w_state_nxt = ST_RUN;
                  w_cnt_nxt   = 2'd0;
               end
            end
            ST_STALL: begin
               if (r_cnt <= 2'd1) begin
                  w_state_nxt = ST_RUN;
                  w_cnt_nxt   = 2'd0;
               end else begin
                  w_cnt_nxt = r_cnt - 2'd1;
               end
            end
            default: begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = 2'd0;
            end
         endcase
      end
   end

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
      rs1_fwd_sel  = 2'b00;
      rs2_fwd_sel  = 2'b00;
      if (reset) begin
         pc_write = 1'b1;
      end else if (kill) begin
         id_ex_bubble = 1'b1;
         if_id_flush  = 1'b1;
         rs1_fwd_sel  = w_rs1_fwd;
         rs2_fwd_sel  = w_rs2_fwd;
      end else if (w_stall) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
      end else begin
         if_id_flush = branch && branch_taken;
         rs1_fwd_sel = w_rs1_fwd;
         rs2_fwd_sel = w_rs2_fwd;
      end
   end

   assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed pipeline scenarios then random traffic,
// all compared against a remaining-stall-count reference model.
module tb_hazard_stall_ctrl;

   localparam int REG_AW = 5;
   localparam int LU_S   = 1;
   localparam int AB_S   = 1;
   localparam int LB_S   = 2;
   localparam int CNT_W  = 5;
   localparam int PMAX   = (1 << CNT_W) - 1;

   logic              clk;
   logic              reset;
   logic [REG_AW-1:0] if_id_rs1, if_id_rs2;
   logic              if_id_use_rs1, if_id_use_rs2;
   logic              branch, branch_taken;
   logic [REG_AW-1:0] id_ex_rd;
   logic              id_ex_mem_read, id_ex_reg_write;
   logic [REG_AW-1:0] ex_mem_rd;
   logic              ex_mem_mem_read, ex_mem_reg_write;
   logic [REG_AW-1:0] mem_wb_rd;
   logic              mem_wb_reg_write;
   logic              kill;
   logic              pc_write, if_id_write, id_ex_bubble, if_id_flush;
   logic [1:0]        rs1_fwd_sel, rs2_fwd_sel;
   logic [CNT_W-1:0]  stall_cycles;

   int checks = 0;
   int errors = 0;
   int m_rem  = 0;
   int m_perf = 0;

   hazard_stall_ctrl #(
      .REG_AW(REG_AW), .LU_STALLS(LU_S), .AB_STALLS(AB_S),
      .LB_STALLS(LB_S), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
      .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
      .branch(branch), .branch_taken(branch_taken),
      .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
      .id_ex_reg_write(id_ex_reg_write),
      .ex_mem_rd(ex_mem_rd), .ex_mem_mem_read(ex_mem_mem_read),
      .ex_mem_reg_write(ex_mem_reg_write),
      .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
      .kill(kill),
      .pc_write(pc_write), .if_id_write(if_id_write),
      .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
      .rs1_fwd_sel(rs1_fwd_sel), .rs2_fwd_sel(rs2_fwd_sel),
      .stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit hit(input logic [4:0] rd, input logic [4:0] rs, input logic u);
      return u && (rd != 0) && (rd == rs);
   endfunction

   function automatic int need_stalls();
      bit idh, exh;
      idh = hit(id_ex_rd, if_id_rs1, if_id_use_rs1) || hit(id_ex_rd, if_id_rs2, if_id_use_rs2);
      exh = hit(ex_mem_rd, if_id_rs1, if_id_use_rs1) || hit(ex_mem_rd, if_id_rs2, if_id_use_rs2);
      if (branch && id_ex_reg_write && idh) return id_ex_mem_read ? LB_S : AB_S;
      if (branch && ex_mem_mem_read && ex_mem_reg_write && exh) return LB_S - 1;
      if (!branch && id_ex_mem_read && id_ex_reg_write && idh) return LU_S;
      return 0;
   endfunction

   function automatic logic [1:0] exp_sel(input logic [4:0] rs, input logic u);
      if (!branch) return 2'd0;
      if (ex_mem_reg_write && !ex_mem_mem_read && hit(ex_mem_rd, rs, u)) return 2'd1;
      if (mem_wb_reg_write && hit(mem_wb_rd, rs, u)) return 2'd2;
      return 2'd0;
   endfunction

   task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic br, input logic tk,
                        input logic [4:0] exd, input logic exmr, input logic exrw,
                        input logic [4:0] mmd, input logic mmmr, input logic mmrw,
                        input logic [4:0] wbd, input logic wbrw,
                        input logic kl, input logic rst);
      if_id_rs1 = rs1; if_id_rs2 = rs2; if_id_use_rs1 = u1; if_id_use_rs2 = u2;
      branch = br; branch_taken = tk;
      id_ex_rd = exd; id_ex_mem_read = exmr; id_ex_reg_write = exrw;
      ex_mem_rd = mmd; ex_mem_mem_read = mmmr; ex_mem_reg_write = mmrw;
      mem_wb_rd = wbd; mem_wb_reg_write = wbrw;
      kill = kl; reset = rst;
   endtask

   // One cycle: predict outputs from the model, compare at negedge, advance model at posedge.
   task automatic step();
      bit st;
      int n;
      logic e_pc, e_ifw, e_bub, e_fl;
      logic [1:0] e_s1, e_s2;
      @(negedge clk);
      st = 0;
      e_pc = 1; e_ifw = 1; e_bub = 0; e_fl = 0; e_s1 = 0; e_s2 = 0;
      chk("stall_cycles", 32'(stall_cycles), 32'(m_perf));
      if (reset) begin
         m_rem = 0;
         m_perf = 0;
      end else if (kill) begin
         e_bub = 1; e_fl = 1;
         e_s1 = exp_sel(if_id_rs1, if_id_use_rs1);
         e_s2 = exp_sel(if_id_rs2, if_id_use_rs2);
         m_rem = 0;
      end else if (m_rem > 0) begin
         st = 1;
         m_rem--;
      end else begin
         n = need_stalls();
         if (n > 0) begin
            st = 1;
            m_rem = n - 1;
         end else begin
            e_fl = branch && branch_taken;
            e_s1 = exp_sel(if_id_rs1, if_id_use_rs1);
            e_s2 = exp_sel(if_id_rs2, if_id_use_rs2);
         end
      end
      if (st) begin
         e_pc = 0; e_ifw = 0; e_bub = 1;
         if (m_perf < PMAX) m_perf++;
      end
      chk("pc_write", 32'(pc_write), 32'(e_pc));
      chk("if_id_write", 32'(if_id_write), 32'(e_ifw));
      chk("id_ex_bubble", 32'(id_ex_bubble), 32'(e_bub));
      chk("if_id_flush", 32'(if_id_flush), 32'(e_fl));
      chk("rs1_fwd_sel", 32'(rs1_fwd_sel), 32'(e_s1));
      chk("rs2_fwd_sel", 32'(rs2_fwd_sel), 32'(e_s2));
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,1);
      @(posedge clk);
      #1;
      step();
      step();

      // load-use: lw x5 ; add x6, x5, x1
      drive(5,1,1,1,0,0, 5,1,1, 0,0,0, 0,0, 0,0);
      step();
      drive(5,1,1,1,0,0, 0,0,0, 5,1,1, 0,0, 0,0);
      step();
      chk("lu_perf", 32'(stall_cycles), 32'd1);

      // ALU -> branch: add x7 ; beq x7, x2
      drive(7,2,1,1,1,0, 7,0,1, 0,0,0, 0,0, 0,0);
      step();
      drive(7,2,1,1,1,0, 0,0,0, 7,0,1, 0,0, 0,0);
      step();
      chk("ab_rs1_sel", 32'(rs1_fwd_sel), 32'd1);
      chk("ab_rs2_sel", 32'(rs2_fwd_sel), 32'd0);

      // load -> branch: lw x8 ; bne x3, x8 (two stalls, then MEM/WB forward)
      drive(3,8,1,1,1,0, 8,1,1, 0,0,0, 0,0, 0,0);
      step();
      drive(3,8,1,1,1,0, 0,0,0, 8,1,1, 0,0, 0,0);
      step();
      drive(3,8,1,1,1,0, 0,0,0, 0,0,0, 8,1, 0,0);
      step();
      chk("lb_rs2_sel", 32'(rs2_fwd_sel), 32'd2);
      chk("lb_perf", 32'(stall_cycles), 32'd4);

      // x0 destination and unused sources never stall
      drive(0,0,1,1,1,0, 0,1,1, 0,0,0, 0,0, 0,0);
      step();
      drive(5,5,0,0,1,0, 5,1,1, 5,1,1, 5,1, 0,0);
      step();
      chk("x0_perf", 32'(stall_cycles), 32'd4);

      // kill in the second cycle of a load -> branch stall
      drive(3,8,1,1,1,0, 8,1,1, 0,0,0, 0,0, 0,0);
      step();
      drive(3,8,1,1,1,0, 0,0,0, 0,0,0, 0,0, 1,0);
      step();
      drive(3,8,1,1,1,0, 0,0,0, 0,0,0, 0,0, 0,0);
      step();
      chk("kill_resume", 32'(pc_write), 32'd1);

      // reset in the second cycle of a load -> branch stall
      drive(3,8,1,1,1,0, 8,1,1, 0,0,0, 0,0, 0,0);
      step();
      drive(3,8,1,1,1,0, 8,1,1, 0,0,0, 0,0, 0,1);
      step();
      drive(3,8,1,1,1,0, 0,0,0, 0,0,0, 0,0, 0,0);
      step();
      chk("rst_perf", 32'(stall_cycles), 32'd0);

      // taken branch, no hazard
      drive(1,2,1,1,1,1, 0,0,0, 0,0,0, 0,0, 0,0);
      step();

      for (int i = 0; i < 600; i++) begin
         drive(5'($urandom_range(0,3)), 5'($urandom_range(0,3)),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               5'($urandom_range(0,3)), 1'($urandom), 1'($urandom),
               5'($urandom_range(0,3)), 1'($urandom), 1'($urandom),
               5'($urandom_range(0,3)), 1'($urandom),
               1'($urandom_range(0,15) == 0), 1'($urandom_range(0,63) == 0));
         step();
      end

      // saturation of the stall counter
      drive(5,1,1,1,0,0, 5,1,1, 0,0,0, 0,0, 0,0);
      for (int i = 0; i < 40; i++) step();
      chk("sat_perf", 32'(stall_cycles), 32'(PMAX));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
